// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target with an Avalon-MM register port.
package i2c_pkg;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_RX_BYTE,
      ST_RX_ACK,
      ST_TX_BYTE,
      ST_TX_ACK
   } i2c_state_e;

   localparam int DATA_W = 8;

   localparam logic [3:0] REG_CTRL    = 4'd0;
   localparam logic [3:0] REG_STATUS  = 4'd1;
   localparam logic [3:0] REG_DATA    = 4'd2;
   localparam logic [3:0] REG_OWNADDR = 4'd3;

   localparam int STAT_RX_NONEMPTY = 0;
   localparam int STAT_TX_FULL     = 1;
   localparam int STAT_BUSY        = 2;
   localparam int STAT_RX_OVF      = 3;
   localparam int STAT_TX_UND      = 4;
   localparam int STAT_STOP        = 5;
endpackage

// File: rtl/i2c_sync_fifo.sv
// Byte FIFO with first-word-fall-through read; push when full and pop when empty are ignored.
module i2c_sync_fifo
   import i2c_pkg::*;
#(
   parameter int depth = 4
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic              flush_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              full_o,
   output logic              empty_o
);
   localparam int AW = $clog2(depth);

   logic [DATA_W-1:0] mem_q [depth];
   logic [AW:0]       wr_ptr_q;
   logic [AW:0]       rd_ptr_q;
   logic              do_push;
   logic              do_pop;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk_i) begin
      if (srst_i || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end
endmodule

// File: rtl/i2c_target_avalon.sv
// I2C target answering one fixed address; written bytes land in an RX FIFO and
// read bytes come from a host-filled TX FIFO, both reachable over Avalon-MM.
module i2c_target_avalon
   import i2c_pkg::*;
#(
   parameter logic [6:0] i2cSlaveAddress = 7'b1001001,
   parameter int         FifoDepth       = 4
) (
   input  logic        avs_clock,
   input  logic        avs_reset,
   input  logic [3:0]  avs_address,
   input  logic        avs_write,
   input  logic        avs_read,
   input  logic [7:0]  avs_write_data,
   output logic [7:0]  avs_read_data,
   inout  wire         scl,
   inout  wire         sda
);
   logic scl_meta_q, scl_sync_q, scl_prev_q;
   logic sda_meta_q, sda_sync_q, sda_prev_q;
   logic scl_rise, scl_fall, start_det, stop_det;

   i2c_state_e state_q;
   logic [7:0] shift_q;
   logic [3:0] bit_cnt_q;
   logic       phase_q, ack_q, rw_q, sda_low_q, busy_q;
   logic       rx_push_q, ovf_set_q, tx_pop_q, und_set_q, stop_set_q;
   logic       enable_q, rx_ovf_q, tx_und_q, stop_seen_q;

   logic [7:0] rx_rdata, tx_rdata, tx_byte_w, status_w, rd_mux;
   logic       rx_full, rx_empty, tx_full, tx_empty;
   logic       ctrl_wr, stat_wr, flush, tx_push, rx_pop;

   assign sda = sda_low_q ? 1'b0 : 1'bz;

   always_ff @(posedge avs_clock) begin
      if (avs_reset) begin
         {scl_meta_q, scl_sync_q, scl_prev_q} <= 3'b111;
         {sda_meta_q, sda_sync_q, sda_prev_q} <= 3'b111;
      end else begin
         {scl_meta_q, scl_sync_q, scl_prev_q} <= {scl, scl_meta_q, scl_sync_q};
         {sda_meta_q, sda_sync_q, sda_prev_q} <= {sda, sda_meta_q, sda_sync_q};
      end
   end

   assign scl_rise  = scl_sync_q && !scl_prev_q;
   assign scl_fall  = !scl_sync_q && scl_prev_q;
   assign start_det = scl_sync_q && scl_prev_q && sda_prev_q && !sda_sync_q;
   assign stop_det  = scl_sync_q && scl_prev_q && !sda_prev_q && sda_sync_q;
   assign tx_byte_w = tx_empty ? 8'hFF : tx_rdata;

   always_ff @(posedge avs_clock) begin
      if (avs_reset) begin
         state_q    <= ST_IDLE;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         phase_q    <= 1'b0;
         ack_q      <= 1'b0;
         rw_q       <= 1'b0;
         sda_low_q  <= 1'b0;
         busy_q     <= 1'b0;
         rx_push_q  <= 1'b0;
         ovf_set_q  <= 1'b0;
         tx_pop_q   <= 1'b0;
         und_set_q  <= 1'b0;
         stop_set_q <= 1'b0;
      end else begin
         rx_push_q  <= 1'b0;
         ovf_set_q  <= 1'b0;
         tx_pop_q   <= 1'b0;
         und_set_q  <= 1'b0;
         stop_set_q <= 1'b0;
         if (start_det) begin
            state_q   <= ST_ADDR;
            bit_cnt_q <= '0;
            sda_low_q <= 1'b0;
            busy_q    <= 1'b0;
         end else if (stop_det) begin
            state_q    <= ST_IDLE;
            sda_low_q  <= 1'b0;
            busy_q     <= 1'b0;
            stop_set_q <= busy_q;
         end else begin
            case (state_q)
               ST_ADDR: if (scl_rise) begin
                  shift_q   <= {shift_q[6:0], sda_sync_q};
                  bit_cnt_q <= bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     if (enable_q && shift_q[6:0] == i2cSlaveAddress) begin
                        state_q <= ST_ADDR_ACK;
                        rw_q    <= sda_sync_q;
                        busy_q  <= 1'b1;
                        phase_q <= 1'b0;
                     end else begin
                        state_q <= ST_IDLE;
                     end
                  end
               end
               ST_ADDR_ACK: if (scl_fall) begin
                  if (!phase_q) begin
                     sda_low_q <= 1'b1;
                     phase_q   <= 1'b1;
                  end else if (!rw_q) begin
                     sda_low_q <= 1'b0;
                     bit_cnt_q <= '0;
                     state_q   <= ST_RX_BYTE;
                  end else begin
                     shift_q   <= tx_byte_w;
                     sda_low_q <= !tx_byte_w[7];
                     tx_pop_q  <= !tx_empty;
                     und_set_q <= tx_empty;
                     bit_cnt_q <= '0;
                     state_q   <= ST_TX_BYTE;
                  end
               end
               ST_RX_BYTE: if (scl_rise) begin
                  shift_q   <= {shift_q[6:0], sda_sync_q};
                  bit_cnt_q <= bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     // shift_q holds the completed byte when the push pulse lands.
                     state_q   <= ST_RX_ACK;
                     phase_q   <= 1'b0;
                     ack_q     <= !rx_full;
                     rx_push_q <= !rx_full;
                     ovf_set_q <= rx_full;
                  end
               end
               ST_RX_ACK: if (scl_fall) begin
                  if (!phase_q) begin
                     sda_low_q <= ack_q;
                     phase_q   <= 1'b1;
                  end else begin
                     sda_low_q <= 1'b0;
                     bit_cnt_q <= '0;
                     state_q   <= ST_RX_BYTE;
                  end
               end
               ST_TX_BYTE: begin
                  if (scl_rise) begin
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                  end else if (scl_fall) begin
                     if (bit_cnt_q == 4'd8) begin
                        sda_low_q <= 1'b0;
                        ack_q     <= 1'b0;
                        state_q   <= ST_TX_ACK;
                     end else begin
                        shift_q   <= {shift_q[6:0], 1'b0};
                        sda_low_q <= !shift_q[6];
                     end
                  end
               end
               ST_TX_ACK: begin
                  if (scl_rise) begin
                     if (sda_sync_q) state_q <= ST_IDLE;
                     else            ack_q   <= 1'b1;
                  end else if (scl_fall && ack_q) begin
                     shift_q   <= tx_byte_w;
                     sda_low_q <= !tx_byte_w[7];
                     tx_pop_q  <= !tx_empty;
                     und_set_q <= tx_empty;
                     bit_cnt_q <= '0;
                     state_q   <= ST_TX_BYTE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign ctrl_wr = avs_write && (avs_address == REG_CTRL);
   assign stat_wr = avs_write && (avs_address == REG_STATUS);
   assign flush   = ctrl_wr && avs_write_data[1];
   assign tx_push = avs_write && (avs_address == REG_DATA);
   assign rx_pop  = avs_read && (avs_address == REG_DATA);

   i2c_sync_fifo #(.depth(FifoDepth)) u_rx_fifo (
      .clk_i(avs_clock), .srst_i(avs_reset), .push_i(rx_push_q), .pop_i(rx_pop),
      .flush_i(flush), .wdata_i(shift_q), .rdata_o(rx_rdata), .full_o(rx_full), .empty_o(rx_empty)
   );

   i2c_sync_fifo #(.depth(FifoDepth)) u_tx_fifo (
      .clk_i(avs_clock), .srst_i(avs_reset), .push_i(tx_push), .pop_i(tx_pop_q),
      .flush_i(flush), .wdata_i(avs_write_data), .rdata_o(tx_rdata), .full_o(tx_full), .empty_o(tx_empty)
   );

   always_comb begin
      status_w                   = '0;
      status_w[STAT_RX_NONEMPTY] = !rx_empty;
      status_w[STAT_TX_FULL]     = tx_full;
      status_w[STAT_BUSY]        = busy_q;
      status_w[STAT_RX_OVF]      = rx_ovf_q;
      status_w[STAT_TX_UND]      = tx_und_q;
      status_w[STAT_STOP]        = stop_seen_q;
      rd_mux = '0;
      case (avs_address)
         REG_CTRL:    rd_mux = {7'd0, enable_q};
         REG_STATUS:  rd_mux = status_w;
         REG_DATA:    rd_mux = rx_empty ? 8'd0 : rx_rdata;
         REG_OWNADDR: rd_mux = {1'b0, i2cSlaveAddress};
         default:     ;
      endcase
   end

   // Sticky flags: a bus-side set in the same cycle as a host clear wins.
   always_ff @(posedge avs_clock) begin
      if (avs_reset) begin
         enable_q      <= 1'b0;
         rx_ovf_q      <= 1'b0;
         tx_und_q      <= 1'b0;
         stop_seen_q   <= 1'b0;
         avs_read_data <= '0;
      end else begin
         if (ctrl_wr) enable_q <= avs_write_data[0];
         rx_ovf_q    <= (rx_ovf_q && !(stat_wr && avs_write_data[STAT_RX_OVF])) || ovf_set_q;
         tx_und_q    <= (tx_und_q && !(stat_wr && avs_write_data[STAT_TX_UND])) || und_set_q;
         stop_seen_q <= (stop_seen_q && !(stat_wr && avs_write_data[STAT_STOP])) || stop_set_q;
         if (avs_read) avs_read_data <= rd_mux;
      end
   end
endmodule

// File: tb/tb_i2c_target_avalon.sv
// Bench: an I2C controller model drives the bus while queue-based FIFO/flag models predict the target.
module tb_i2c_target_avalon;
   import i2c_pkg::*;

   localparam int Q = 5;
   localparam logic [6:0] OWN = 7'h49;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1;
   logic [3:0] addr = '0;
   logic       wr = 1'b0, rd = 1'b0;
   logic [7:0] wdata = '0;
   logic [7:0] rdata;
   logic       scl_drv = 1'b1, sda_low = 1'b0;
   wire        scl, sda;

   assign scl = scl_drv;
   assign sda = sda_low ? 1'b0 : 1'bz;
   pullup (sda);

   i2c_target_avalon dut (
      .avs_clock(clk), .avs_reset(rst), .avs_address(addr), .avs_write(wr),
      .avs_read(rd), .avs_write_data(wdata), .avs_read_data(rdata), .scl(scl), .sda(sda)
   );

   int n_checks = 0, n_errors = 0;
   logic [7:0] rx_q[$];
   logic [7:0] tx_q[$];
   bit m_en, m_ovf, m_und, m_stop, m_busy;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic host_write(input logic [3:0] a, input logic [7:0] d);
      addr = a; wdata = d; wr = 1'b1;
      @(negedge clk);
      wr = 1'b0;
   endtask

   task automatic host_read(input logic [3:0] a, output logic [7:0] d);
      addr = a; rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
      d = rdata;
   endtask

   task automatic model_reset();
      rx_q.delete(); tx_q.delete();
      m_en = 0; m_ovf = 0; m_und = 0; m_stop = 0; m_busy = 0;
   endtask

   task automatic m_push(input logic [7:0] d);
      host_write(REG_DATA, d);
      if (tx_q.size() < 4) tx_q.push_back(d);
   endtask

   task automatic m_pop_rx(input string tag);
      logic [7:0] d, e;
      host_read(REG_DATA, d);
      e = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
      check(tag, d, e);
   endtask

   task automatic m_status(input string tag);
      logic [7:0] d;
      host_read(REG_STATUS, d);
      check(tag, d, {2'b00, m_stop, m_und, m_ovf, m_busy, tx_q.size() == 4, rx_q.size() != 0});
   endtask

   task automatic m_clear(input logic [7:0] v);
      host_write(REG_STATUS, v);
      if (v[3]) m_ovf = 0;
      if (v[4]) m_und = 0;
      if (v[5]) m_stop = 0;
   endtask

   task automatic m_ctrl(input logic [7:0] v);
      host_write(REG_CTRL, v);
      m_en = v[0];
      if (v[1]) begin rx_q.delete(); tx_q.delete(); end
   endtask

   task automatic bus_start();
      sda_low = 1'b0; clks(Q);
      scl_drv = 1'b1; clks(Q);
      sda_low = 1'b1; clks(Q);
      scl_drv = 1'b0; clks(Q);
      m_busy = 0;
   endtask

   task automatic bus_stop();
      sda_low = 1'b1; clks(Q);
      scl_drv = 1'b1; clks(Q);
      sda_low = 1'b0; clks(2 * Q);
      if (m_busy) m_stop = 1;
      m_busy = 0;
   endtask

   task automatic bit_w(input logic b);
      sda_low = ~b; clks(Q);
      scl_drv = 1'b1; clks(2 * Q);
      scl_drv = 1'b0; clks(Q);
   endtask

   task automatic bit_r(output logic b);
      sda_low = 1'b0; clks(Q);
      scl_drv = 1'b1; clks(Q);
      b = sda; clks(Q);
      scl_drv = 1'b0; clks(Q);
   endtask

   task automatic m_addr(input logic [6:0] a7, input logic rw, output bit ok);
      logic b;
      for (int i = 6; i >= 0; i--) bit_w(a7[i]);
      bit_w(rw);
      bit_r(b);
      ok = m_en && (a7 == OWN);
      check("addr_ack", {7'd0, b}, {7'd0, !ok});
      if (ok) m_busy = 1;
   endtask

   task automatic m_wr(input logic [7:0] d);
      logic b;
      bit acc;
      for (int i = 7; i >= 0; i--) bit_w(d[i]);
      bit_r(b);
      acc = (rx_q.size() < 4);
      if (acc) rx_q.push_back(d);
      else     m_ovf = 1;
      check("wr_ack", {7'd0, b}, {7'd0, !acc});
   endtask

   task automatic m_rd(input logic nack);
      logic [7:0] d, e;
      logic b;
      for (int i = 7; i >= 0; i--) begin
         bit_r(b);
         d[i] = b;
      end
      bit_w(nack);
      if (tx_q.size() != 0) e = tx_q.pop_front();
      else begin e = 8'hFF; m_und = 1; end
      check("rd_byte", d, e);
   endtask

   task automatic rand_txn(input int idx);
      logic [6:0] a7;
      logic       rw;
      bit         ok;
      int         n, r;
      r = $urandom_range(0, 7);
      if (r == 0)      m_ctrl(8'h00);
      else if (r == 1) m_ctrl(8'h03);
      else if (!m_en)  m_ctrl(8'h01);
      repeat ($urandom_range(0, 3)) m_push(8'($urandom_range(0, 255)));
      a7 = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : OWN;
      rw = 1'($urandom_range(0, 1));
      n  = $urandom_range(1, 5);
      $display("txn %0d addr=%02h rw=%0d n=%0d en=%0d", idx, a7, rw, n, m_en);
      bus_start();
      m_addr(a7, rw, ok);
      if (ok) begin
         for (int i = 0; i < n; i++) begin
            if (rw) m_rd(i == n - 1);
            else    m_wr(8'($urandom_range(0, 255)));
         end
      end
      bus_stop();
      repeat ($urandom_range(0, 4)) m_pop_rx("rnd_rx");
      m_status("rnd_status");
      if ($urandom_range(0, 1) == 1) m_clear(8'h38);
   endtask

   initial begin
      logic [7:0] d;
      bit ok;
      model_reset();
      clks(4);
      rst = 1'b0;
      clks(2);
      check("rst_rdata", rdata, 8'h00);
      check("rst_sda", {7'd0, sda}, 8'h01);
      m_status("rst_status");
      host_read(REG_CTRL, d);    check("rst_ctrl", d, 8'h00);
      host_read(REG_OWNADDR, d); check("ownaddr", d, {1'b0, OWN});
      host_read(4'd9, d);        check("unmapped", d, 8'h00);

      m_ctrl(8'h01);
      $display("txn addressed write");
      bus_start(); m_addr(OWN, 1'b0, ok);
      m_status("busy_open");
      m_wr(8'h55); m_wr(8'h77); bus_stop();
      m_status("wr_status");
      m_pop_rx("wr_rx0"); m_pop_rx("wr_rx1"); m_pop_rx("rx_empty_read");
      m_clear(8'h38);

      $display("txn addressed read");
      m_push(8'hA5); m_push(8'h3C);
      bus_start(); m_addr(OWN, 1'b1, ok);
      m_rd(1'b0); m_rd(1'b1); bus_stop();
      m_status("rd_status");
      m_clear(8'h38);

      $display("txn address mismatch");
      bus_start(); m_addr(7'h48, 1'b0, ok); bus_stop();
      m_status("mismatch_status");

      $display("txn rx overflow");
      bus_start(); m_addr(OWN, 1'b0, ok);
      for (int i = 1; i <= 5; i++) m_wr(8'(i));
      bus_stop();
      m_status("ovf_status");
      for (int i = 0; i < 4; i++) m_pop_rx("ovf_rx");
      m_clear(8'h08);
      m_status("ovf_cleared");

      $display("txn tx underrun");
      bus_start(); m_addr(OWN, 1'b1, ok); m_rd(1'b1); bus_stop();
      m_status("und_status");
      m_clear(8'h38);

      $display("txn repeated start");
      m_push(8'h5A);
      bus_start(); m_addr(OWN, 1'b0, ok); m_wr(8'h11);
      bus_start(); m_addr(OWN, 1'b1, ok); m_rd(1'b1); bus_stop();
      m_pop_rx("rs_rx");
      m_status("rs_status");

      $display("txn flush");
      m_push(8'h01); m_push(8'h02); m_push(8'h03); m_push(8'h04); m_push(8'h05);
      m_status("tx_full_status");
      m_ctrl(8'h03);
      m_status("flush_status");

      for (int t = 0; t < 16; t++) rand_txn(t);

      $display("txn reset mid-transfer");
      m_ctrl(8'h01);
      bus_start(); m_addr(OWN, 1'b0, ok);
      for (int i = 7; i >= 0; i--) bit_w(1'b1);
      sda_low = 1'b0;
      clks(Q);
      check("ack_driven", {7'd0, sda}, 8'h00);
      rst = 1'b1;
      @(negedge clk);
      check("rst_sda_release", {7'd0, sda}, 8'h01);
      check("rst_rdata2", rdata, 8'h00);
      rst = 1'b0;
      model_reset();
      scl_drv = 1'b1;
      clks(2 * Q);
      m_status("rst_status2");
      host_read(REG_CTRL, d); check("rst_ctrl2", d, 8'h00);
      m_pop_rx("rst_rx_empty");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
